// File: rtl/output_aggregator.sv
// Output aggregator: return end of the layer-multiplex handshake.
// Collects per-neuron results from the shared neuron layer after each layer
// start and presents them, with per-neuron valid flags, as the next layer's
// input bus. Flags completion (layer_done) and abort (timeout) per layer.
module output_aggregator #(
   parameter  int LAYER_MAX  = 3,
   parameter  int NUM_NEURON = 6,
   parameter  int INPUT_SIZE = 9,
   parameter  int TIMEOUT    = 255,
   localparam int LN_W       = $clog2(LAYER_MAX) + 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             layer_start,
   input  logic [NUM_NEURON-1:0]            active,
   input  logic [LN_W-1:0]                  layer_num,
   input  logic [NUM_NEURON*INPUT_SIZE-1:0] neuron_outputs,
   input  logic [NUM_NEURON-1:0]            neuron_valid,
   output logic [NUM_NEURON*INPUT_SIZE-1:0] layer_output,
   output logic [NUM_NEURON-1:0]            layer_output_valid,
   output logic [LN_W-1:0]                  captured_layer,
   output logic                             layer_done,
   output logic                             timeout,
   output logic                             busy
);

   // Counter only has to reach TIMEOUT-1; it wraps harmlessly when TIMEOUT=0.
   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_COLLECT,
      S_DONE
   } state_t;

   state_t                          state_q, state_d;
   logic [NUM_NEURON*INPUT_SIZE-1:0] data_q, data_d;
   logic [NUM_NEURON-1:0]           valid_q, valid_d;
   logic [NUM_NEURON-1:0]           mask_q, mask_d;
   logic [LN_W-1:0]                 layer_q, layer_d;
   logic [CNT_W-1:0]                cnt_q, cnt_d;
   logic                            done_q, done_d;
   logic                            timeout_q, timeout_d;

   logic [NUM_NEURON-1:0]           capture;
   logic [NUM_NEURON-1:0]           next_valid;
   logic                            complete;
   logic                            expired;

   // State, collected data and pulse registers; synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the data slices are reset too, because they drive the next
         // layer's input bus directly and must never show power-up garbage.
         state_q   <= S_IDLE;
         data_q    <= '0;
         valid_q   <= '0;
         mask_q    <= '0;
         layer_q   <= '0;
         cnt_q     <= '0;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge value of every other register, independent of order.
         state_q   <= state_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         mask_q    <= mask_d;
         layer_q   <= layer_d;
         cnt_q     <= cnt_d;
         done_q    <= done_d;
         timeout_q <= timeout_d;
      end
   end

   // Next-state logic: layer_start restarts from any state; COLLECT captures
   // first strobes only and decides completion on the post-capture vector.
   always_comb begin
      // NOTE: every signal assigned here gets a default first so no path
      // leaves one unassigned, which would otherwise infer a latch.
      state_d   = state_q;
      data_d    = data_q;
      valid_d   = valid_q;
      mask_d    = mask_q;
      layer_d   = layer_q;
      cnt_d     = cnt_q;
      done_d    = 1'b0;
      timeout_d = 1'b0;

      capture    = neuron_valid & mask_q & ~valid_q;
      next_valid = valid_q | capture;
      complete   = ((next_valid & mask_q) == mask_q);
      expired    = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

      if (layer_start) begin
         // Data is deliberately kept; only validity is dropped.
         state_d = S_COLLECT;
         valid_d = '0;
         mask_d  = active;
         layer_d = layer_num;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_COLLECT: begin
               valid_d = next_valid;
               for (int i = 0; i < NUM_NEURON; i++) begin
                  if (capture[i]) begin
                     data_d[i*INPUT_SIZE +: INPUT_SIZE] = neuron_outputs[i*INPUT_SIZE +: INPUT_SIZE];
                  end
               end
               cnt_d = cnt_q + 1'b1;
               if (complete) begin
                  state_d = S_DONE;
               end else if (expired) begin
                  state_d   = S_IDLE;
                  timeout_d = 1'b1;
               end
            end
            S_DONE: begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
            S_IDLE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign layer_output       = data_q;
   assign layer_output_valid = valid_q;
   assign captured_layer     = layer_q;
   assign layer_done         = done_q;
   assign timeout            = timeout_q;
   assign busy               = (state_q == S_COLLECT);

endmodule

// File: tb/tb_output_aggregator.sv
// Testbench for output_aggregator: directed layer sequences with literal
// expectations, plus a per-cycle comparison against a behavioural model.
module tb_output_aggregator;

   localparam int NN = 6;
   localparam int IS = 9;
   localparam int TO = 8;
   localparam int LW = 3;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            layer_start = 1'b0;
   logic [NN-1:0]   active = '0;
   logic [LW-1:0]   layer_num = '0;
   logic [NN*IS-1:0] neuron_outputs = '0;
   logic [NN-1:0]   neuron_valid = '0;
   logic [NN*IS-1:0] layer_output;
   logic [NN-1:0]   layer_output_valid;
   logic [LW-1:0]   captured_layer;
   logic            layer_done;
   logic            timeout;
   logic            busy;

   always #5 clk = ~clk;

   output_aggregator #(
      .LAYER_MAX (3),
      .NUM_NEURON(NN),
      .INPUT_SIZE(IS),
      .TIMEOUT   (TO)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .layer_start       (layer_start),
      .active            (active),
      .layer_num         (layer_num),
      .neuron_outputs    (neuron_outputs),
      .neuron_valid      (neuron_valid),
      .layer_output      (layer_output),
      .layer_output_valid(layer_output_valid),
      .captured_layer    (captured_layer),
      .layer_done        (layer_done),
      .timeout           (timeout),
      .busy              (busy)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a layer is "open" from a start until every enabled
   // neuron has reported or TO cycles have elapsed. Results are kept per
   // neuron; the done pulse appears one cycle after the layer closes.
   logic [NN*IS-1:0] m_out = '0;
   logic [NN-1:0]    m_valid = '0;
   logic [NN-1:0]    m_mask = '0;
   logic [LW-1:0]    m_layer = '0;
   bit               m_open = 0;
   bit               m_done_pending = 0;
   bit               m_done = 0;
   bit               m_to = 0;
   bit               m_armed = 0;
   int               m_age = 0;

   always @(posedge clk) begin
      m_done = 0;
      m_to   = 0;
      if (rst) begin
         m_out = '0; m_valid = '0; m_mask = '0; m_layer = '0;
         m_open = 0; m_done_pending = 0; m_age = 0;
         m_armed = 1;
      end else begin
         m_done = m_done_pending && !layer_start;
         m_done_pending = 0;
         if (layer_start) begin
            m_valid = '0;
            m_mask  = active;
            m_layer = layer_num;
            m_open  = 1;
            m_age   = 0;
         end else if (m_open) begin
            m_age++;
            for (int i = 0; i < NN; i++) begin
               if (neuron_valid[i] && m_mask[i] && !m_valid[i]) begin
                  m_valid[i] = 1'b1;
                  m_out[i*IS +: IS] = neuron_outputs[i*IS +: IS];
               end
            end
            if ((m_valid & m_mask) == m_mask) begin
               m_open = 0;
               m_done_pending = 1;
            end else if (TO != 0 && m_age == TO) begin
               m_open = 0;
               m_to = 1;
            end
         end
      end
   end

   // Compare every DUT output against the model on the falling edge.
   always @(negedge clk) begin
      if (m_armed) begin
         check("model layer_output", layer_output, m_out);
         check("model valid", layer_output_valid, m_valid);
         check("model captured_layer", captured_layer, m_layer);
         check("model layer_done", layer_done, m_done);
         check("model timeout", timeout, m_to);
         check("model busy", busy, m_open);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      layer_start  = 1'b0;
      neuron_valid = '0;
   endtask

   task automatic start(input logic [NN-1:0] act, input logic [LW-1:0] ln);
      layer_start  = 1'b1;
      active       = act;
      layer_num    = ln;
      neuron_valid = '0;
   endtask

   task automatic strobe(input int idx, input logic [IS-1:0] val);
      neuron_valid[idx] = 1'b1;
      neuron_outputs[idx*IS +: IS] = val;
   endtask

   initial begin
      // Reset state.
      step(); step();
      check("reset layer_output", layer_output, 0);
      check("reset valid", layer_output_valid, 0);
      check("reset captured_layer", captured_layer, 0);
      check("reset busy", busy, 0);
      check("reset layer_done", layer_done, 0);
      rst = 1'b0;

      // Full mask, one neuron per cycle, values 1..6.
      start(6'b111111, 3'd0); step();
      check("full busy after start", busy, 1);
      check("full valid cleared", layer_output_valid, 0);
      idle();
      for (int i = 0; i < NN; i++) begin
         neuron_valid = '0;
         strobe(i, 9'(i + 1));
         step();
         check("full valid ramp", layer_output_valid, (64'd1 << (i + 1)) - 64'd1);
      end
      check("full busy low at completion", busy, 0);
      check("full no early done", layer_done, 0);
      idle(); step();
      check("full layer_done", layer_done, 1);
      check("full busy during done", busy, 0);
      step();
      check("full done one cycle", layer_done, 0);
      check("full data", layer_output, {9'd6, 9'd5, 9'd4, 9'd3, 9'd2, 9'd1});

      // Partial mask, all strobes at once; disabled slices keep old data.
      start(6'b000111, 3'd1); step();
      check("partial valid cleared", layer_output_valid, 0);
      check("partial captured_layer", captured_layer, 1);
      idle();
      for (int i = 0; i < NN; i++) strobe(i, 9'(10 + i));
      step();
      check("partial valid", layer_output_valid, 6'b000111);
      check("partial data", layer_output, {9'd6, 9'd5, 9'd4, 9'd12, 9'd11, 9'd10});
      idle(); step();
      check("partial layer_done", layer_done, 1);
      step();

      // Repeat strobe: first value wins.
      start(6'b001100, 3'd2); step();
      idle(); strobe(2, 9'd5); step();
      check("repeat first capture", layer_output_valid, 6'b000100);
      neuron_valid = '0; strobe(2, 9'd9); step();
      check("repeat slice kept", layer_output[2*IS +: IS], 5);
      check("repeat still busy", busy, 1);
      neuron_valid = '0; strobe(3, 9'd7); step();
      check("repeat completes", layer_output_valid, 6'b001100);
      idle(); step();
      check("repeat layer_done", layer_done, 1);
      step();

      // Empty mask.
      start(6'b000000, 3'd3); step();
      check("empty busy", busy, 1);
      check("empty captured_layer", captured_layer, 3);
      idle(); step();
      check("empty busy drops", busy, 0);
      check("empty no done yet", layer_done, 0);
      step();
      check("empty layer_done", layer_done, 1);
      check("empty valid", layer_output_valid, 0);
      step();
      check("empty done one cycle", layer_done, 0);

      // Timeout after 8 COLLECT cycles with one of two neurons reported.
      start(6'b000011, 3'd4); step();
      idle(); strobe(0, 9'd33); step();
      check("timeout partial valid", layer_output_valid, 6'b000001);
      idle();
      repeat (6) step();
      check("timeout not yet", timeout, 0);
      check("timeout still busy", busy, 1);
      step();
      check("timeout pulse", timeout, 1);
      check("timeout busy low", busy, 0);
      check("timeout no done", layer_done, 0);
      step();
      check("timeout one cycle", timeout, 0);
      check("timeout valid held", layer_output_valid, 6'b000001);
      check("timeout still no done", layer_done, 0);

      // Completion in the last allowed cycle beats timeout.
      start(6'b000001, 3'd5); step();
      idle();
      repeat (7) step();
      check("race busy", busy, 1);
      strobe(0, 9'd77); step();
      check("race no timeout", timeout, 0);
      check("race busy low", busy, 0);
      idle(); step();
      check("race layer_done", layer_done, 1);
      check("race still no timeout", timeout, 0);
      step();

      // layer_start while in DONE suppresses the pending done pulse.
      start(6'b000001, 3'd7); step();
      idle(); strobe(0, 9'd21); step();
      check("done-restart in done", busy, 0);
      start(6'b000010, 3'd1); step();
      check("done-restart suppressed", layer_done, 0);
      check("done-restart busy", busy, 1);
      check("done-restart valid", layer_output_valid, 0);
      check("done-restart layer", captured_layer, 1);
      idle(); strobe(1, 9'd22); step();
      idle(); step();
      check("done-restart layer_done", layer_done, 1);
      step();

      // Restart mid-collect, then synchronous reset mid-collect.
      start(6'b000111, 3'd5); step();
      idle(); strobe(0, 9'd1); step();
      neuron_valid = '0; strobe(1, 9'd2); step();
      check("restart two captured", layer_output_valid, 6'b000011);
      start(6'b111000, 3'd6); step();
      check("restart valid cleared", layer_output_valid, 0);
      check("restart captured_layer", captured_layer, 6);
      check("restart busy", busy, 1);
      idle(); strobe(3, 9'd40); step();
      check("restart capture", layer_output_valid, 6'b001000);
      idle(); rst = 1'b1; step();
      check("rst layer_output", layer_output, 0);
      check("rst valid", layer_output_valid, 0);
      check("rst captured_layer", captured_layer, 0);
      check("rst busy", busy, 0);
      rst = 1'b0; step();
      check("rst no done", layer_done, 0);
      check("rst no timeout", timeout, 0);
      repeat (2) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
